mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter N, default 32, data and address width.
REQ-002 SHALL have parameter MAX_STREAK, default 4, consecutive data grants allowed while a fetch waits.
REQ-003 SHALL have parameter TIMEOUT, default 64, cycles allowed for mem_ack.
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 if_req / if_addr  input  1 / N  instruction-fetch read request and address.
REQ-007 if_flush  input  1  pulse that cancels the pending or in-flight fetch.
REQ-008 if_ack / if_rdata  output  1 / N  fetch completion pulse and read data.
REQ-009 d_req / d_we / d_addr / d_wdata  input  1 / 1 / N / N  data-stage request, write enable, address, write data.
REQ-010 d_ack / d_rdata  output  1 / N  data completion pulse and read data.
REQ-011 stall_if / stall_d  output  1 / 1  pipeline stalls, equal to x_req AND NOT x_ack.
REQ-012 mem_req / mem_we / mem_addr / mem_wdata  output  1 / 1 / N / N  shared memory port.
REQ-013 mem_ack / mem_rdata  input  1 / N  access complete; mem_rdata valid in the mem_ack cycle.
REQ-014 bus_err  output  1  one-cycle pulse, coincident with x_ack, on a timed-out access.

Function
REQ-015 FSM states SHALL be IDLE, ISSUE_IF, ISSUE_D and RESP.
REQ-016 IDLE SHALL arbitrate each cycle and register the winner's address, we and wdata.
- Winner is d_req, unless streak == MAX_STREAK and if_req, in which case the winner is IF.
- if_req with if_flush in the same cycle SHALL NOT win.
REQ-017 ISSUE_x SHALL hold mem_req=1 with stable mem_addr, mem_we and mem_wdata until mem_ack, then move to RESP; mem_we SHALL be 0 in ISSUE_IF.
REQ-018 RESP SHALL assert exactly one of if_ack/d_ack for one cycle, with x_rdata registered from mem_rdata (write: d_rdata = 0), then return to IDLE.
REQ-019 Latency: request seen in IDLE at cycle t gives mem_req at t+1; mem_ack at t+1+k (k>=0) gives x_ack at t+2+k; minimum 2 cycles.
REQ-020 Requesters hold x_req and operands until x_ack; x_req high in the cycle after x_ack SHALL be treated as a new request.
REQ-021 streak SHALL increment on each data grant made while if_req was high, saturating at MAX_STREAK.
- streak SHALL clear on an IF grant, or on a data grant made with if_req low.
REQ-022 if_flush during ISSUE_IF SHALL set a discard flag.
- The access completes on the memory side; RESP then suppresses if_ack.
- if_flush in RESP of an IF access SHALL suppress that cycle's if_ack.
- The discard flag clears on entry to IDLE.
REQ-023 if_flush SHALL NOT affect data accesses.
REQ-024 A wait counter SHALL run in ISSUE_x.
- At TIMEOUT cycles without mem_ack: drop mem_req, enter RESP, return rdata 0, pulse bus_err with x_ack.
- A mem_ack arriving after the timeout SHALL be ignored in IDLE.
REQ-025 mem_req SHALL be 0 in IDLE and RESP; mem_ack outside ISSUE_x SHALL be ignored.

Reset
REQ-026 Reset SHALL force IDLE and clear streak, wait counter and discard flag.
REQ-027 Reset SHALL force mem_req, mem_we, if_ack, d_ack and bus_err to 0, and mem_addr, mem_wdata, if_rdata and d_rdata to 0.
REQ-028 Reset mid-access SHALL abandon the access without any ack.

Structure
REQ-029 The FSM state encoding and the MAX_STREAK/TIMEOUT defaults SHALL live in the shared pipeline package.
REQ-030 The streak and timeout counters SHALL be one sub-module, arb_counters; everything else stays in mem_port_arbiter.

Verification
REQ-031 Verification SHALL cover, at minimum, the following directed scenarios:
- if_req only, addr 0x10, mem_ack after 1 cycle of mem_req -> mem_req 1 cycle later, if_ack 3 cycles after request, if_rdata = mem_rdata.
- if_req and d_req held continuously, mem_ack immediate -> grant order D,D,D,D,IF,D,D,D,D,IF.
- d_req write 0xDEADBEEF to 0x40 -> mem_we=1, mem_wdata=0xDEADBEEF held until mem_ack, d_ack with d_rdata=0.
- if_flush while in ISSUE_IF -> no if_ack, mem_req held until mem_ack, next d_req served normally.
- mem_ack never asserted -> mem_req drops after 64 cycles, next cycle d_ack=1, bus_err=1, d_rdata=0.
- reset asserted during ISSUE_D -> mem_req 0 immediately, no d_ack, state IDLE.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_pkg
// Shared definitions for the instruction-fetch / data-stage memory arbiter:
// FSM state encoding, default fairness and timeout limits, and the requester
// identifier used to route a completed access back to its owner.
// -----------------------------------------------------------------------------
package mem_port_arbiter_pkg;

    // Default number of back-to-back data grants while a fetch is waiting.
    localparam int DEF_MAX_STREAK = 4;
    // Default number of cycles an access may wait for mem_ack.
    localparam int DEF_TIMEOUT    = 64;

    // FSM state encoding.
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_ISSUE_IF = 2'd1;
    localparam logic [1:0] ST_ISSUE_D  = 2'd2;
    localparam logic [1:0] ST_RESP     = 2'd3;

    // Which requester owns the access currently in flight.
    typedef enum logic {
        SRC_IF = 1'b0,
        SRC_D  = 1'b1
    } src_e;

endpackage

// File: rtl/arb_counters.sv
// -----------------------------------------------------------------------------
// arb_counters
// Fairness streak counter and memory wait (timeout) counter for
// mem_port_arbiter.
//
// Ports
//   clk_i          clock, all state on rising edge
//   reset_i        asynchronous active-high reset
//   d_grant_i      data access granted this cycle
//   if_grant_i     fetch access granted this cycle
//   if_req_i       fetch request level (raw, as seen by the arbiter)
//   wait_en_i      an access is waiting for mem_ack this cycle
//   streak_full_o  streak has reached MAX_STREAK
//   timeout_o      this is the TIMEOUT-th waiting cycle without mem_ack
// -----------------------------------------------------------------------------
module arb_counters
    import mem_port_arbiter_pkg::*;
#(
    parameter int MAX_STREAK = DEF_MAX_STREAK,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic d_grant_i,
    input  logic if_grant_i,
    input  logic if_req_i,
    input  logic wait_en_i,
    output logic streak_full_o,
    output logic timeout_o
);

    localparam int SW = (MAX_STREAK > 0) ? $clog2(MAX_STREAK + 1) : 1;
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [SW-1:0] streak_q, streak_d;
    logic [WW-1:0] wait_q, wait_d;

    assign streak_full_o = (streak_q == SW'(MAX_STREAK));
    // wait_q counts completed waiting cycles, so the cycle where it equals
    // TIMEOUT-1 is the last one mem_req may stay high.
    assign timeout_o     = wait_en_i && (wait_q == WW'(TIMEOUT - 1));

    always_comb begin
        streak_d = streak_q;
        if (if_grant_i) begin
            streak_d = '0;
        end else if (d_grant_i) begin
            // Only data grants that actually made a fetch wait count.
            if (!if_req_i) begin
                streak_d = '0;
            end else if (!streak_full_o) begin
                streak_d = streak_q + SW'(1);
            end
        end
    end

    always_comb begin
        wait_d = '0;
        if (wait_en_i && !timeout_o) begin
            wait_d = wait_q + WW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            streak_q <= '0;
            wait_q   <= '0;
        end else begin
            streak_q <= streak_d;
            wait_q   <= wait_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-outstanding memory port between an instruction-fetch
// requester and a data-stage requester. Data wins by default; after
// MAX_STREAK consecutive data grants with a fetch waiting, the fetch wins.
// Fetches can be flushed; accesses without mem_ack for TIMEOUT cycles
// complete with zero data and a bus_err pulse.
//
// Ports
//   clk, reset                     clock, async active-high reset
//   if_req/if_addr/if_flush        fetch request, address, cancel pulse
//   if_ack/if_rdata                fetch completion pulse and data
//   d_req/d_we/d_addr/d_wdata      data request and operands
//   d_ack/d_rdata                  data completion pulse and data
//   stall_if/stall_d               x_req & ~x_ack
//   mem_req/mem_we/mem_addr/mem_wdata  shared memory port (outputs)
//   mem_ack/mem_rdata              memory completion and read data
//   bus_err                        timed-out access, coincident with x_ack
// -----------------------------------------------------------------------------
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int N          = 32,
    parameter int MAX_STREAK = DEF_MAX_STREAK,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         if_req,
    input  logic [N-1:0] if_addr,
    input  logic         if_flush,
    output logic         if_ack,
    output logic [N-1:0] if_rdata,
    input  logic         d_req,
    input  logic         d_we,
    input  logic [N-1:0] d_addr,
    input  logic [N-1:0] d_wdata,
    output logic         d_ack,
    output logic [N-1:0] d_rdata,
    output logic         stall_if,
    output logic         stall_d,
    output logic         mem_req,
    output logic         mem_we,
    output logic [N-1:0] mem_addr,
    output logic [N-1:0] mem_wdata,
    input  logic         mem_ack,
    input  logic [N-1:0] mem_rdata,
    output logic         bus_err
);

    logic [1:0]   state_q, state_d;
    src_e         owner_q;
    logic         discard_q, discard_d;
    logic         tmo_q, tmo_d;
    logic [N-1:0] addr_q, wdata_q, if_rdata_q, d_rdata_q;
    logic         we_q;

    logic         in_idle, in_issue, in_resp;
    logic         if_valid, grant_if, grant_d;
    logic         streak_full, timeout, acc_done;
    logic [N-1:0] resp_data;

    assign in_idle  = (state_q == ST_IDLE);
    assign in_resp  = (state_q == ST_RESP);
    assign in_issue = (state_q == ST_ISSUE_IF) || (state_q == ST_ISSUE_D);

    // A fetch being flushed in the same cycle is not a candidate.
    assign if_valid = if_req && !if_flush;
    assign grant_if = in_idle && if_valid && (streak_full || !d_req);
    assign grant_d  = in_idle && d_req && !(streak_full && if_valid);

    // mem_ack has priority over a timeout reached in the same cycle.
    assign acc_done  = in_issue && (mem_ack || timeout);
    assign resp_data = (mem_ack && !we_q) ? mem_rdata : '0;

    arb_counters #(
        .MAX_STREAK (MAX_STREAK),
        .TIMEOUT    (TIMEOUT)
    ) u_counters (
        .clk_i         (clk),
        .reset_i       (reset),
        .d_grant_i     (grant_d),
        .if_grant_i    (grant_if),
        .if_req_i      (if_req),
        .wait_en_i     (in_issue),
        .streak_full_o (streak_full),
        .timeout_o     (timeout)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_d) begin
                    state_d = ST_ISSUE_D;
                end else if (grant_if) begin
                    state_d = ST_ISSUE_IF;
                end
            end
            ST_ISSUE_IF, ST_ISSUE_D: begin
                if (acc_done) begin
                    state_d = ST_RESP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        discard_d = discard_q;
        tmo_d     = tmo_q;
        if (in_resp) begin
            // Leaving RESP is the only way into IDLE.
            discard_d = 1'b0;
            tmo_d     = 1'b0;
        end else begin
            if ((state_q == ST_ISSUE_IF) && if_flush) begin
                discard_d = 1'b1;
            end
            if (in_issue && !mem_ack && timeout) begin
                tmo_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            owner_q    <= SRC_IF;
            discard_q  <= 1'b0;
            tmo_q      <= 1'b0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            discard_q <= discard_d;
            tmo_q     <= tmo_d;
            if (grant_d) begin
                owner_q <= SRC_D;
                addr_q  <= d_addr;
                we_q    <= d_we;
                wdata_q <= d_wdata;
            end else if (grant_if) begin
                owner_q <= SRC_IF;
                addr_q  <= if_addr;
                we_q    <= 1'b0;
                wdata_q <= '0;
            end
            if (acc_done) begin
                if (owner_q == SRC_D) begin
                    d_rdata_q <= resp_data;
                end else begin
                    if_rdata_q <= resp_data;
                end
            end
        end
    end

    assign mem_req   = in_issue;
    assign mem_we    = in_issue && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    // A flushed fetch still finishes on the memory side but is never acked.
    assign if_ack   = in_resp && (owner_q == SRC_IF) && !discard_q && !if_flush;
    assign d_ack    = in_resp && (owner_q == SRC_D);
    assign bus_err  = tmo_q && (if_ack || d_ack);
    assign if_rdata = if_rdata_q;
    assign d_rdata  = d_rdata_q;
    assign stall_if = if_req && !if_ack;
    assign stall_d  = d_req && !d_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Self-checking bench: the bench plays both requesters and the memory.
// A transaction-level model predicts the winner of each arbitration from the
// fairness rules (integer streak), the memory latency it chooses, and the
// data each requester must receive.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int MAX_S = 4;
    localparam int TMO   = 64;

    logic        clk;
    logic        reset;
    logic        if_req, if_flush, if_ack;
    logic [31:0] if_addr, if_rdata;
    logic        d_req, d_we, d_ack;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        stall_if, stall_d;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        bus_err;

    int n_tests = 0;
    int n_fail  = 0;
    int streak  = 0;   // model: data grants in a row while a fetch waited

    bit exp_order [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

    mem_port_arbiter #(
        .N          (32),
        .MAX_STREAK (MAX_S),
        .TIMEOUT    (TMO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_flush  (if_flush),
        .if_ack    (if_ack),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_ack     (d_ack),
        .d_rdata   (d_rdata),
        .stall_if  (stall_if),
        .stall_d   (stall_d),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .bus_err   (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic new_if();
        if_req  = 1'b1;
        if_addr = $urandom;
    endtask

    task automatic new_d();
        d_req   = 1'b1;
        d_addr  = $urandom;
        d_we    = 1'($urandom_range(0, 1));
        d_wdata = $urandom;
    endtask

    // One complete access starting in an IDLE cycle with requests already
    // driven. k = extra cycles of mem_req before mem_ack; tmo = never ack.
    task automatic xact(input int k, input bit tmo, input bit fl_iss,
                        input bit fl_resp, output bit won_d);
        bit          wd, ewe, flushed, ifack_e, dack_e;
        logic [31:0] ea, ewd, rd;
        int          lat;

        wd = d_req && !((streak == MAX_S) && if_req);
        if (wd) begin
            streak = if_req ? ((streak < MAX_S) ? streak + 1 : streak) : 0;
            ea = d_addr; ewe = d_we; ewd = d_wdata;
        end else begin
            streak = 0;
            ea = if_addr; ewe = 1'b0; ewd = '0;
        end
        flushed = 1'b0;

        tick();
        mem_ack = 1'b0;
        check("issue_mem_req", mem_req, 1);
        check("issue_mem_addr", mem_addr, ea);
        check("issue_mem_we", mem_we, ewe);
        if (wd) check("issue_mem_wdata", mem_wdata, ewd);
        check("issue_stall_if", stall_if, if_req);
        check("issue_stall_d", stall_d, d_req);
        if (!wd && fl_iss) begin
            if_flush = 1'b1;
            if_req   = 1'b0;
            flushed  = 1'b1;
        end

        lat = tmo ? TMO - 1 : k;
        rd  = $urandom;
        for (int j = 0; j < lat; j++) begin
            tick();
            if_flush = 1'b0;
            check("hold_mem_req", mem_req, 1);
            check("hold_mem_addr", mem_addr, ea);
            check("hold_mem_we", mem_we, ewe);
            if (wd) check("hold_mem_wdata", mem_wdata, ewd);
        end
        if (!tmo) begin
            mem_ack   = 1'b1;
            mem_rdata = rd;
        end
        tick();
        if_flush  = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
        if (!wd && fl_resp && !flushed) begin
            if_flush = 1'b1;
            if_req   = 1'b0;
            flushed  = 1'b1;
        end
        #1;
        ifack_e = !wd && !flushed;
        dack_e  = wd;
        check("resp_mem_req", mem_req, 0);
        check("resp_if_ack", if_ack, ifack_e);
        check("resp_d_ack", d_ack, dack_e);
        check("resp_bus_err", bus_err, tmo && (ifack_e || dack_e));
        if (dack_e) check("resp_d_rdata", d_rdata, (tmo || ewe) ? 32'h0 : rd);
        if (ifack_e) check("resp_if_rdata", if_rdata, tmo ? 32'h0 : rd);
        check("resp_stall_if", stall_if, if_req && !ifack_e);
        check("resp_stall_d", stall_d, d_req && !dack_e);
        if (tmo) begin
            // Late ack across RESP and the following IDLE cycle.
            mem_ack   = 1'b1;
            mem_rdata = $urandom;
        end

        tick();
        if_flush = 1'b0;
        check("idle_mem_req", mem_req, 0);
        check("idle_if_ack", if_ack, 0);
        check("idle_d_ack", d_ack, 0);
        check("idle_bus_err", bus_err, 0);
        if (wd) d_req = 1'b0;
        else    if_req = 1'b0;
        won_d = wd;
    endtask

    initial begin
        bit won;
        int k;
        bit tmo, fl_i, fl_r;

        reset = 1'b1;
        if_req = 0; if_flush = 0; if_addr = '0;
        d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
        mem_ack = 0; mem_rdata = '0;
        tick();
        tick();
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_if_ack", if_ack, 0);
        check("rst_d_ack", d_ack, 0);
        check("rst_bus_err", bus_err, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_if_rdata", if_rdata, 0);
        check("rst_d_rdata", d_rdata, 0);
        reset = 1'b0;

        // Both requesters always pending, immediate ack.
        new_if();
        new_d();
        for (int i = 0; i < 10; i++) begin
            xact(0, 0, 0, 0, won);
            check("grant_order", won, exp_order[i]);
            if (won) new_d();
            else     new_if();
        end
        if_req = 0;
        d_req  = 0;

        // Fetch only at 0x10, ack after one cycle of mem_req.
        if_req = 1; if_addr = 32'h10;
        xact(1, 0, 0, 0, won);
        check("if_only_winner", won, 0);

        // Data write.
        d_req = 1; d_we = 1; d_addr = 32'h40; d_wdata = 32'hDEADBEEF;
        xact(2, 0, 0, 0, won);
        check("write_winner", won, 1);

        // Flush during ISSUE_IF, then a normal data read.
        new_if();
        xact(2, 0, 1, 0, won);
        d_req = 1; d_we = 0; d_addr = 32'h80;
        xact(1, 0, 0, 0, won);
        check("after_flush_winner", won, 1);

        // Data read that never gets mem_ack.
        d_req = 1; d_we = 0; d_addr = 32'hC0;
        xact(0, 1, 0, 0, won);

        // Flush in the RESP cycle of a fetch.
        new_if();
        xact(1, 0, 0, 1, won);

        // Randomized traffic.
        for (int it = 0; it < 300; it++) begin
            if (!if_req && $urandom_range(0, 1) == 1) new_if();
            if (!d_req && $urandom_range(0, 1) == 1) new_d();
            if (!if_req && !d_req) begin
                tick();
                check("idle_no_req", mem_req, 0);
                if ($urandom_range(0, 1) == 1) new_if();
                else new_d();
            end
            k    = $urandom_range(0, 3);
            tmo  = ($urandom_range(0, 23) == 0);
            fl_i = !tmo && ($urandom_range(0, 5) == 0);
            fl_r = !tmo && !fl_i && ($urandom_range(0, 5) == 0);
            xact(k, tmo, fl_i, fl_r, won);
        end

        // Reset in the middle of a data access.
        mem_ack = 0;
        if_req  = 0;
        d_req = 1; d_we = 0; d_addr = 32'h1234;
        tick();
        check("pre_rst_mem_req", mem_req, 1);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_mem_req", mem_req, 0);
        check("mid_rst_d_ack", d_ack, 0);
        tick();
        reset = 1'b0;
        d_req = 0;
        streak = 0;
        check("post_rst_d_ack", d_ack, 0);
        tick();
        check("post_rst_mem_req", mem_req, 0);
        check("post_rst_d_ack2", d_ack, 0);
        d_req = 1; d_we = 0; d_addr = 32'h5678;
        xact(0, 0, 0, 0, won);
        check("post_rst_winner", won, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
